font_rom_arbiter: RTL and testbench

- Shares the single synchronous font ROM (2048 x 8, 16 rows per glyph) between up to NUM_REQ text renderers, for example title, start prompt, card ranks and card suits.
- Each cycle, a round-robin arbiter grants one pending request and drives the granted address to the ROM.
- The returned glyph row is routed back to the granted requester with a per-requester valid pulse.
- The block sits between the screen/text renderers and the font ROM instance at top level.

---
 rtl/font_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/font_rom_arbiter.sv | 91 +++++++++
 tb/tb_font_rom_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/font_pkg.sv
// Shared font ROM geometry, glyph codes and glyph address helper
// used by the text renderers and the font ROM arbiter.
package font_pkg;

   localparam int FONT_ADDR_W = 11;
   localparam int FONT_DATA_W = 8;
   localparam int GLYPH_ROWS  = 16;

   localparam logic [7:0] CH_HEART   = 8'h03;
   localparam logic [7:0] CH_DIAMOND = 8'h04;
   localparam logic [7:0] CH_CLUB    = 8'h05;
   localparam logic [7:0] CH_SPADE   = 8'h06;
   localparam logic [7:0] CH_ACE     = 8'h41;

   // 128 glyphs of 16 rows fill the ROM, so the code MSB falls off the top.
   function automatic logic [FONT_ADDR_W-1:0] glyph_addr(input logic [7:0] code,
                                                         input logic [3:0] row);
      return FONT_ADDR_W'({code, row});
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// after ptr, wrapping modulo N; returns a one-hot grant and its index.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IDX_W = $clog2(N);

   always_comb begin : scan
      logic             found;
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] cand;
      // NOTE: every output and scratch variable gets a default first so no latch is inferred.
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         // ptr + k < 2N, so one extra bit and one conditional subtract wrap it for any N.
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
         end
         cand = sum[IDX_W-1:0];
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/font_rom_arbiter.sv
// Round-robin sharing of the single synchronous font ROM between NUM_REQ
// text renderers, with a tag pipeline routing each glyph row back to its requester.
module font_rom_arbiter
   import font_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = FONT_ADDR_W,
   parameter int DATA_W  = FONT_DATA_W,
   parameter int ROM_LAT = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      line_start,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_gnt,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_data,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tag_t;

   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   ptr_next;
   logic [IDX_W-1:0]   arb_idx;
   logic [NUM_REQ-1:0] arb_gnt;
   logic               grant;
   logic [ADDR_W-1:0]  grant_addr;
   tag_t               tag_q [0:ROM_LAT];

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr_arbiter (
      .req (req_valid),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   assign req_gnt    = reset ? '0 : arb_gnt;
   assign grant      = |req_gnt;
   assign grant_addr = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];

   // line_start rewinds after this cycle's grant, which already used the old ptr.
   always_comb begin
      ptr_next = ptr;
      if (line_start) begin
         ptr_next = '0;
      end else if (grant) begin
         ptr_next = (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignment so the tag shift sees pre-edge values.
      if (reset) begin
         ptr      <= '0;
         rom_addr <= '0;
         for (int k = 0; k <= ROM_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         ptr <= ptr_next;
         if (grant) begin
            rom_addr <= grant_addr;
         end
         tag_q[0] <= '{valid: grant, idx: arb_idx};
         for (int k = 1; k <= ROM_LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (tag_q[ROM_LAT].valid) begin
         rsp_valid[tag_q[ROM_LAT].idx] = 1'b1;
      end
   end

   // NOTE: rsp_data is a plain wire from the ROM; only control state is reset, rsp_valid qualifies it.
   assign rsp_data = rom_data;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Scoreboard bench: drives a ROM_LAT=1 and a ROM_LAT=2 arbiter with identical
// stimulus and checks grants, ROM address and tagged responses every cycle.
module tb_font_rom_arbiter;
   import font_pkg::*;

   localparam int NR = 4;
   localparam int AW = 11;
   localparam int DW = 8;

   typedef struct {
      int             cyc;
      int             idx;
      logic [DW-1:0]  data;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             line_start;
   logic [NR-1:0]    req_valid;
   logic [NR*AW-1:0] req_addr;

   logic [NR-1:0]    gnt1, gnt2;
   logic [AW-1:0]    rom_addr1, rom_addr2;
   logic [DW-1:0]    rom_data1, rom_data2, rom_pipe2;
   logic [NR-1:0]    rsp_valid1, rsp_valid2;
   logic [DW-1:0]    rsp_data1, rsp_data2;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         ptr_m = 0;
   logic [AW-1:0] rom_addr_m = '0;
   bit         known = 1'b0;
   int         last_g = -1;
   exp_t       q1[$];
   exp_t       q2[$];
   logic [NR-1:0] pend;
   logic [7:0] codes [5];

   always #5 clk = ~clk;

   font_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u_dut_l1 (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_gnt    (gnt1),
      .rom_addr   (rom_addr1),
      .rom_data   (rom_data1),
      .rsp_valid  (rsp_valid1),
      .rsp_data   (rsp_data1)
   );

   font_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) u_dut_l2 (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_gnt    (gnt2),
      .rom_addr   (rom_addr2),
      .rom_data   (rom_data2),
      .rsp_valid  (rsp_valid2),
      .rsp_data   (rsp_data2)
   );

   function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
      return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'h5A;
   endfunction

   // Font ROM models: one and two cycles of read latency.
   always @(posedge clk) begin
      rom_data1 <= rom_fn(rom_addr1);
      rom_pipe2 <= rom_fn(rom_addr2);
      rom_data2 <= rom_pipe2;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] v, input int p);
      for (int k = 0; k < NR; k++) begin
         if (v[(p + k) % NR]) return (p + k) % NR;
      end
      return -1;
   endfunction

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   task automatic check_rsp(input string tag, inout exp_t q[$],
                            input logic [NR-1:0] rv, input logic [DW-1:0] rd);
      logic [NR-1:0] exp_rv;
      exp_t e;
      exp_rv = '0;
      e = '{cyc: 0, idx: 0, data: '0};
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         exp_rv = NR'(1 << e.idx);
      end
      check({tag, "_valid"}, 32'(rv), 32'(exp_rv));
      if (exp_rv != '0) check({tag, "_data"}, 32'(rd), 32'(e.data));
   endtask

   // One clock: compare at negedge, then advance the reference model.
   task automatic tick();
      int g;
      logic [NR-1:0] eg;
      logic [AW-1:0] a;
      @(negedge clk);
      g  = reset ? -1 : pick(req_valid, ptr_m);
      eg = (g >= 0) ? NR'(1 << g) : '0;
      check("req_gnt_l1", 32'(gnt1), 32'(eg));
      check("req_gnt_l2", 32'(gnt2), 32'(eg));
      if (known) begin
         check("rom_addr_l1", 32'(rom_addr1), 32'(rom_addr_m));
         check("rom_addr_l2", 32'(rom_addr2), 32'(rom_addr_m));
         check_rsp("rsp_l1", q1, rsp_valid1, rsp_data1);
         check_rsp("rsp_l2", q2, rsp_valid2, rsp_data2);
      end
      if (reset) begin
         q1.delete();
         q2.delete();
         ptr_m      = 0;
         rom_addr_m = '0;
         known      = 1'b1;
      end else begin
         if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            q1.push_back('{cyc: cyc + 2, idx: g, data: rom_fn(a)});
            q2.push_back('{cyc: cyc + 3, idx: g, data: rom_fn(a)});
            rom_addr_m = a;
         end
         if (line_start)  ptr_m = 0;
         else if (g >= 0) ptr_m = (g + 1) % NR;
      end
      last_g = g;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      req_valid  = '0;
      line_start = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      codes = '{CH_HEART, CH_DIAMOND, CH_CLUB, CH_SPADE, CH_ACE};
      reset      = 1'b1;
      line_start = 1'b0;
      req_valid  = '1;
      req_addr   = '0;
      pend       = '0;
      @(posedge clk);
      #1;

      // Reset holds grants low even with every request pending.
      tick();
      tick();
      reset = 1'b0;
      idle(1);

      // Single request at ace row 0 (11'h410).
      set_addr(0, glyph_addr(CH_ACE, 4'd0));
      req_valid = 4'b0001;
      tick();
      idle(4);

      // All four requesters, after rewinding ptr: 0,1,2,3,0.
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      set_addr(0, 11'h030);
      set_addr(1, 11'h040);
      set_addr(2, 11'h050);
      set_addr(3, 11'h060);
      req_valid = 4'b1111;
      repeat (5) tick();
      idle(3);

      // Wrap: grant 2 leaves ptr at 3, then 1001 grants 3 then 0.
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b1001;
      tick();
      tick();
      idle(3);

      // line_start while ptr = 2: grant 2 this cycle, then 0 rather than 3.
      req_valid = 4'b0010;
      tick();
      req_valid  = 4'b1111;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      tick();
      idle(3);

      // Reset with two grants in flight, then a normal grant to requester 2.
      req_valid = 4'b1111;
      tick();
      tick();
      req_valid  = '0;
      reset      = 1'b1;
      line_start = 1'b1;
      tick();
      reset      = 1'b0;
      idle(3);
      set_addr(2, glyph_addr(CH_SPADE, 4'd7));
      req_valid = 4'b0100;
      tick();
      idle(4);

      // Randomised traffic obeying the hold-until-granted protocol, with withdrawals.
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               set_addr(i, glyph_addr(codes[$urandom_range(0, 4)], 4'($urandom_range(0, 15))));
            end else if (pend[i] && $urandom_range(0, 19) == 0) begin
               pend[i] = 1'b0;
            end
         end
         req_valid  = pend;
         line_start = ($urandom_range(0, 15) == 0);
         tick();
         if (last_g >= 0) pend[last_g] = 1'b0;
      end
      idle(5);

      check("drain_l1", 32'(q1.size()), 32'd0);
      check("drain_l2", 32'(q2.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
